// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl_pkg
//  Purpose  : Shared types and constants for the data memory controller:
//             controller states, load/store size codes, byte width.
//  Revision : 1.0  initial release
// ============================================================================
package data_mem_ctrl_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_RWAIT = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_e;

   // Size codes match the RISC-V funct3 field of loads/stores
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   // Number of bytes moved for a size code (low two bits only)
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl_if
//  Purpose  : Core request bus plus byte-wide RAM port of the data memory
//             controller. master = core/RAM side, slave = controller.
//  Revision : 1.0  initial release
// ============================================================================
interface data_mem_ctrl_if #(
   parameter int ADDR_W = 16
);
   // core side
   logic              data_read_en;
   logic              data_write_en;
   logic [2:0]        data_size;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [31:0]       rd_data;
   // RAM side
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport master (
      output data_read_en, data_write_en, data_size, addr, wdata, mem_rdata,
      input  busy, done, err, rd_data, mem_addr, mem_re, mem_we, mem_wdata
   );

   modport slave (
      input  data_read_en, data_write_en, data_size, addr, wdata, mem_rdata,
      output busy, done, err, rd_data, mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Sign- or zero-extends the assembled load buffer to 32 bits
//             according to the load size code.
//  Revision : 1.0  initial release
// ============================================================================
module load_extend
   import data_mem_ctrl_pkg::*;
(
   input  logic [31:0] i_buf,
   input  logic [2:0]  i_size,
   output logic [31:0] o_data
);

   // B/H sign-extend, BU/HU zero-extend, word passes through
   always_comb begin
      o_data = i_buf;
      case (i_size)
         SZ_B:    o_data = {{24{i_buf[7]}}, i_buf[7:0]};
         SZ_H:    o_data = {{16{i_buf[15]}}, i_buf[15:0]};
         SZ_BU:   o_data = {24'h0, i_buf[7:0]};
         SZ_HU:   o_data = {16'h0, i_buf[15:0]};
         SZ_W:    o_data = i_buf;
         default: o_data = i_buf;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl
//  Purpose  : Splits core byte/half/word loads and stores into sequences of
//             byte accesses on a byte-wide RAM with one-cycle read latency.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input logic            clk,
   input logic            rst,
   data_mem_ctrl_if.slave bus
);

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_WRITE = S_WRITE;
   localparam logic [2:0] ST_READ  = S_READ;
   localparam logic [2:0] ST_RWAIT = S_RWAIT;
   localparam logic [2:0] ST_DONE  = S_DONE;
   localparam logic [2:0] ST_ERR   = S_ERR;

   logic [2:0]                   state_q, state_d;
   logic [2:0]                   k_q, k_d;          // current byte index
   logic [2:0]                   n_q, n_d;          // bytes in this access
   logic [ADDR_W-1:0]            base_q, base_d;
   logic [3:0][BYTE_W-1:0]       wdata_q, wdata_d;
   logic [3:0][BYTE_W-1:0]       buf_q, buf_d;
   logic [2:0]                   ld_size_q, ld_size_d; // size of the last accepted load

   logic       w_req;
   logic       w_reject;
   logic       w_strobe;
   logic [1:0] w_cap_idx;

   assign w_req    = bus.data_read_en | bus.data_write_en;
   assign w_reject = (bus.data_read_en & bus.data_write_en)
                   | (bus.data_size[1:0] == 2'b11)
                   | (bus.data_size[2] & bus.data_write_en)
                   | ((bus.data_size[1:0] == 2'b01) & bus.addr[0])
                   | ((bus.data_size[1:0] == 2'b10) & (bus.addr[1:0] != 2'b00));
   // read data arrives one cycle after its strobe, so it belongs to byte k-1
   assign w_cap_idx = 2'(k_q - 3'd1);

   // next-state, byte sequencing and load buffer assembly
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      n_d       = n_q;
      base_d    = base_q;
      wdata_d   = wdata_q;
      buf_d     = buf_q;
      ld_size_d = ld_size_q;
      case (state_q)
         ST_IDLE: begin
            if (w_req) begin
               if (w_reject) begin
                  state_d = ST_ERR;
               end else begin
                  base_d  = bus.addr;
                  wdata_d = bus.wdata;
                  n_d     = size_bytes(bus.data_size[1:0]);
                  k_d     = 3'd0;
                  if (bus.data_write_en) begin
                     state_d = ST_WRITE;
                  end else begin
                     state_d   = ST_READ;
                     ld_size_d = bus.data_size;
                     buf_d     = '0;
                  end
               end
            end
         end
         ST_WRITE: begin
            k_d = k_q + 3'd1;
            if (k_q == n_q - 3'd1) state_d = ST_DONE;
         end
         ST_READ: begin
            if (k_q != 3'd0) buf_d[w_cap_idx] = bus.mem_rdata;
            k_d = k_q + 3'd1;
            if (k_q == n_q - 3'd1) state_d = ST_RWAIT;
         end
         ST_RWAIT: begin
            buf_d[w_cap_idx] = bus.mem_rdata;
            state_d          = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         n_q       <= '0;
         base_q    <= '0;
         wdata_q   <= '0;
         buf_q     <= '0;
         ld_size_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         n_q       <= n_d;
         base_q    <= base_d;
         wdata_q   <= wdata_d;
         buf_q     <= buf_d;
         ld_size_q <= ld_size_d;
      end
   end

   // Moore outputs decoded from the current state
   assign w_strobe      = (state_q == ST_WRITE) | (state_q == ST_READ);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_DONE) | (state_q == ST_ERR);
   assign bus.err       = (state_q == ST_ERR);
   assign bus.mem_we    = (state_q == ST_WRITE);
   assign bus.mem_re    = (state_q == ST_READ);
   assign bus.mem_addr  = w_strobe ? (base_q + ADDR_W'(k_q)) : '0;
   assign bus.mem_wdata = (state_q == ST_WRITE) ? wdata_q[k_q[1:0]] : '0;

   load_extend u_load_extend (
      .i_buf  (buf_q),
      .i_size (ld_size_q),
      .o_data (bus.rd_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_ctrl
//  Purpose  : Directed scoreboard bench for data_mem_ctrl with a byte RAM
//             model; stimulus queues expected events, a monitor checks them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      int          c;
   } mem_ev_t;

   typedef struct {
      int          c;
      logic        e;
      logic [31:0] rd;
   } done_ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nvec = 0;
   int   nfail = 0;
   int   busy_lo = 1;
   int   busy_hi = 0;

   mem_ev_t  wq[$];
   mem_ev_t  rq[$];
   done_ev_t dq[$];

   logic [7:0] ram [0:65535];
   logic [7:0] rdata_r = 8'h00;

   data_mem_ctrl_if #(.ADDR_W(16)) bus ();

   data_mem_ctrl #(.ADDR_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // byte RAM: write on strobe, read data registered for next cycle
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re === 1'b1) rdata_r <= ram[bus.mem_addr];
   end
   assign bus.mem_rdata = rdata_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc + 1, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      nvec++;
      nfail++;
      $display("FAIL %s cycle %0d: event seen, none expected", name, cyc + 1);
   endtask

   // monitor: compares every DUT output event against the scoreboard queues
   always @(negedge clk) begin
      int       now;
      mem_ev_t  me;
      done_ev_t de;
      now = cyc + 1;
      chk("busy", 32'(bus.busy), 32'((now >= busy_lo) && (now <= busy_hi)));
      chk("strobe_excl", 32'(bus.mem_we & bus.mem_re), 32'h0);
      if (bus.mem_we === 1'b1) begin
         if (wq.size() == 0) unexpected("write");
         else begin
            me = wq.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), 32'(me.a));
            chk("wr_data", 32'(bus.mem_wdata), 32'(me.d));
            chk("wr_cycle", now, me.c);
         end
      end
      if (bus.mem_re === 1'b1) begin
         if (rq.size() == 0) unexpected("read");
         else begin
            me = rq.pop_front();
            chk("rd_addr", 32'(bus.mem_addr), 32'(me.a));
            chk("rd_cycle", now, me.c);
            chk("rd_wdata_zero", 32'(bus.mem_wdata), 32'h0);
         end
      end
      if (bus.mem_we !== 1'b1 && bus.mem_re !== 1'b1) begin
         chk("idle_addr", 32'(bus.mem_addr), 32'h0);
         chk("idle_wdata", 32'(bus.mem_wdata), 32'h0);
      end
      if (bus.done === 1'b1) begin
         if (dq.size() == 0) unexpected("done");
         else begin
            de = dq.pop_front();
            chk("done_cycle", now, de.c);
            chk("err", 32'(bus.err), 32'(de.e));
            chk("rd_data", bus.rd_data, de.rd);
         end
      end else begin
         chk("err_without_done", 32'(bus.err), 32'h0);
      end
   end

   // issue one request; expected strobes, done cycle and rd_data are queued
   task automatic req(input logic rd, input logic wr, input logic [2:0] sz,
                      input logic [15:0] a, input logic [31:0] wd, input int lat,
                      input logic is_err, input logic [31:0] exp_rd);
      int       t;
      int       n;
      bit       seen;
      mem_ev_t  e;
      done_ev_t d;
      @(negedge clk);
      t = cyc + 1;
      n = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
      if (!is_err) begin
         for (int k = 0; k < n; k++) begin
            e.a = a + 16'(k);
            e.d = wd[8*k +: 8];
            e.c = t + 1 + k;
            if (wr) wq.push_back(e);
            else    rq.push_back(e);
         end
      end
      d.c  = t + lat;
      d.e  = is_err;
      d.rd = exp_rd;
      dq.push_back(d);
      busy_lo = t + 1;
      busy_hi = t + lat;
      bus.data_read_en  = rd;
      bus.data_write_en = wr;
      bus.data_size     = sz;
      bus.addr          = a;
      bus.wdata         = wd;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         nvec++;
         nfail++;
         $display("FAIL done_timeout: no done within 20 cycles for addr %h", a);
      end
      bus.data_read_en  = 1'b0;
      bus.data_write_en = 1'b0;
   endtask

   initial begin
      int      t;
      mem_ev_t e;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      bus.data_read_en  = 1'b0;
      bus.data_write_en = 1'b0;
      bus.data_size     = 3'b000;
      bus.addr          = 16'h0000;
      bus.wdata         = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_rd_data", bus.rd_data, 32'h0);

      //   rd    wr    size    addr      wdata         lat err expected rd_data
      req(1'b0, 1'b1, 3'b010, 16'h0010, 32'h12345678, 5, 0, 32'h00000000); // SW
      req(1'b1, 1'b0, 3'b010, 16'h0010, 32'h0,        6, 0, 32'h12345678); // LW
      req(1'b0, 1'b1, 3'b000, 16'h0013, 32'h00000080, 2, 0, 32'h12345678); // SB
      req(1'b1, 1'b0, 3'b000, 16'h0013, 32'h0,        3, 0, 32'hFFFFFF80); // LB
      req(1'b1, 1'b0, 3'b100, 16'h0013, 32'h0,        3, 0, 32'h00000080); // LBU
      req(1'b0, 1'b1, 3'b001, 16'h0002, 32'h00008001, 3, 0, 32'h00000080); // SH
      req(1'b1, 1'b0, 3'b001, 16'h0002, 32'h0,        4, 0, 32'hFFFF8001); // LH
      req(1'b1, 1'b0, 3'b101, 16'h0002, 32'h0,        4, 0, 32'h00008001); // LHU
      // rejected requests: err with done one cycle after accept, rd_data held
      req(1'b1, 1'b0, 3'b001, 16'h0003, 32'h0,        1, 1, 32'h00008001); // LH odd
      req(1'b0, 1'b1, 3'b010, 16'h0012, 32'hDEADBEEF, 1, 1, 32'h00008001); // SW misaligned
      req(1'b1, 1'b1, 3'b010, 16'h0010, 32'h0,        1, 1, 32'h00008001); // both enables
      req(1'b1, 1'b0, 3'b011, 16'h0010, 32'h0,        1, 1, 32'h00008001); // size 11
      req(1'b0, 1'b1, 3'b100, 16'h0010, 32'h0,        1, 1, 32'h00008001); // unsigned store
      req(1'b1, 1'b0, 3'b010, 16'h0011, 32'h0,        1, 1, 32'h00008001); // LW misaligned
      // top of address space
      req(1'b0, 1'b1, 3'b010, 16'hFFFC, 32'hA1B2C3D4, 5, 0, 32'h00008001); // SW
      req(1'b1, 1'b0, 3'b010, 16'hFFFC, 32'h0,        6, 0, 32'hA1B2C3D4); // LW
      req(1'b1, 1'b0, 3'b001, 16'hFFFE, 32'h0,        4, 0, 32'hFFFFA1B2); // LH
      req(1'b1, 1'b0, 3'b000, 16'hFFFC, 32'h0,        3, 0, 32'hFFFFFFD4); // LB

      // reset in the middle of a store, after two bytes have gone out
      @(negedge clk);
      t = cyc + 1;
      e.a = 16'h0020; e.d = 8'hBE; e.c = t + 1; wq.push_back(e);
      e.a = 16'h0021; e.d = 8'hBA; e.c = t + 2; wq.push_back(e);
      busy_lo = t + 1;
      busy_hi = t + 2;
      bus.data_read_en  = 1'b0;
      bus.data_write_en = 1'b1;
      bus.data_size     = 3'b010;
      bus.addr          = 16'h0020;
      bus.wdata         = 32'hCAFEBABE;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.data_write_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_rd_data", bus.rd_data, 32'h0);
      chk("abort_writes_left", wq.size(), 0);

      req(1'b0, 1'b1, 3'b000, 16'h0021, 32'h0000005A, 2, 0, 32'h00000000); // SB
      req(1'b1, 1'b0, 3'b100, 16'h0020, 32'h0,        3, 0, 32'h000000BE); // LBU
      req(1'b1, 1'b0, 3'b000, 16'h0021, 32'h0,        3, 0, 32'h0000005A); // LB
      req(1'b1, 1'b0, 3'b010, 16'h0020, 32'h0,        6, 0, 32'h00005ABE); // LW

      repeat (3) @(negedge clk);
      chk("writes_left", wq.size(), 0);
      chk("reads_left", rq.size(), 0);
      chk("dones_left", dq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 16, byte-address width of core request and memory port.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- data_read_en  in  1  core load request.
- data_write_en  in  1  core store request.
- data_size  in  3  load/store width code, equal to funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  effective byte address from the ALU.
- wdata  in  32  store data (rs2).
- busy  out  1  high whenever state is not IDLE; the core stalls on it.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done for a rejected request.
- rd_data  out  32  extended load result.
- mem_addr  out  ADDR_W  byte address to byte-wide RAM.
- mem_re  out  1  RAM read strobe; mem_rdata valid exactly one cycle later.
- mem_we  out  1  RAM byte write strobe.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte.

Function
REQ-003 SHALL implement states IDLE, WRITE, READ, RWAIT, DONE, ERR.
REQ-004 SHALL accept a request only in IDLE; requests seen in any other state SHALL be ignored. The core holds the request until done.
REQ-005 On accept, SHALL latch addr, data_size and wdata, and set byte count n = 1/2/4 from data_size[1:0].
REQ-006 SHALL reject a request and go to ERR, with no mem strobe, when any of these holds:
- both enables are high;
- data_size[1:0] is 11;
- data_size is 1xx with a store;
- a halfword has addr[0] = 1;
- a word has addr[1:0] != 0.
REQ-007 ERR SHALL last one cycle with done = 1 and err = 1, then go to IDLE.
REQ-008 Store SHALL run in WRITE for n cycles, byte index k = 0..n-1:
- mem_we = 1;
- mem_addr = base + k;
- mem_wdata = wdata[8k+7:8k] (little-endian).
After the last byte, SHALL go to DONE.
REQ-009 Load SHALL run in READ for n cycles, byte index k = 0..n-1, with mem_re = 1 and mem_addr = base + k. In cycle k ≥ 1 it SHALL capture mem_rdata into buffer byte k-1.
REQ-010 RWAIT SHALL last one cycle, capture byte n-1 with no strobe, then go to DONE.
REQ-011 DONE SHALL last one cycle with done = 1, then go to IDLE.
REQ-012 Latency from the accept edge T: store done at cycle T+n+1; load done at cycle T+n+2; err at cycle T+1.
REQ-013 rd_data SHALL be the buffer sign-extended (B, H) or zero-extended (BU, HU, W).
- Valid in the DONE cycle of a load.
- Held until the next load is accepted.
- The buffer is cleared on load accept.
REQ-014 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-015 mem_re and mem_we SHALL never be high together. Outside WRITE and READ, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-016 rst SHALL force, at the next edge:
- state IDLE;
- busy, done, err, mem_re, mem_we = 0;
- mem_addr, mem_wdata, buffer and rd_data = 0.
REQ-017 Reset mid-operation SHALL abort with no further strobes and no done pulse; RAM bytes already written stay written.

Structure
REQ-018 A shared package SHALL hold:
- the state enum;
- data_size codes SZ_B/SZ_H/SZ_W/SZ_BU/SZ_HU;
- constant BYTE_W = 8.
REQ-019 Sign/zero extension SHALL live in one combinational sub-module, load_extend (buffer and size in, 32-bit result out).

Verification
REQ-020 SW 0x12345678 @0x0010: mem_we bytes 78,56,34,12 at addresses 0x10..0x13 in cycles T+1..T+4; done at T+5; busy high T+1..T+5.
REQ-021 LW @0x0010 after REQ-020: mem_re T+1..T+4; done at T+6; rd_data = 0x12345678.
REQ-022 LB @0x0013 with RAM byte 0x80 gives rd_data 0xFFFFFF80; LBU gives 0x00000080; LH @0x0002 with bytes 01,80 gives 0xFFFF8001; done at T+3 (byte) and T+4 (half).
REQ-023 Rejected requests each give err = done = 1 at T+1 with no strobe:
- LH @0x0003;
- SW @0x0012;
- both enables high.
REQ-024 rst asserted during WRITE after two bytes: next cycle IDLE, mem_we = 0, no done; a following SB completes normally.
